mrd_tag_pool: RTL and testbench

Shared PCIe MRd tag allocator for all S2C scatter-gather channels. Each channel's memory-read requestor asks for a tag before issuing an MRd burst, and the pool grants tags round-robin from a free-list FIFO. The completion demux returns each tag when the last completion for that tag has been consumed. An outstanding-tag bitmap detects illegal and double frees.

---
 rtl/mrd_tag_pool.sv | 201 ++++++++++++++++++++
 tb/tb_mrd_tag_pool.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mrd_tag_pool.sv
// mrd_tag_pool: shared PCIe MRd tag allocator for the S2C scatter-gather
// channels. Tags are handed out round-robin from a free-list FIFO that is
// filled with 0..NUM_TAGS-1 after reset. An outstanding bitmap tracks issued
// tags so that out-of-range or double frees are rejected and flagged.
module mrd_tag_pool #(
  parameter int NUM_CHANS = 4,
  parameter int NUM_TAGS  = 32
) (
  input  logic                      s_axi_clk,
  input  logic                      s_axi_rstn,
  input  logic [NUM_CHANS-1:0]      alloc_tag_req,
  output logic [NUM_CHANS-1:0]      allocated_tag_rdy,
  output logic [7:0]                allocated_tag,
  input  logic                      tag_free_valid,
  input  logic [7:0]                tag_free_tag,
  output logic [$clog2(NUM_TAGS):0] free_count,
  output logic                      init_done,
  output logic                      free_err
);

  localparam int TW   = $clog2(NUM_TAGS);
  localparam int CNTW = TW + 1;
  localparam int CW   = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1;

  localparam logic [8:0]      TAG_LIMIT  = 9'(NUM_TAGS);
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(NUM_TAGS);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [TW-1:0]   PTR_ONE    = TW'(1);
  localparam logic [TW-1:0]   LAST_IDX   = TW'(NUM_TAGS - 1);
  localparam logic [CW-1:0]   LAST_CHAN  = CW'(NUM_CHANS - 1);
  localparam logic [CW-1:0]   CHAN_ONE   = CW'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_r;
  logic [TW-1:0]         init_idx_r;
  logic [TW-1:0]         rd_ptr_r;
  logic [TW-1:0]         wr_ptr_r;
  logic [CNTW-1:0]       count_r;
  logic [NUM_TAGS-1:0]   outstanding_r;
  logic [CW-1:0]         rr_r;
  logic [NUM_CHANS-1:0]  rdy_r;
  logic [7:0]            tag_r;
  logic                  init_done_r;
  logic                  free_err_r;

  logic [7:0]            fifo_mem [NUM_TAGS];

  logic [7:0]            head_tag_s;
  logic [TW-1:0]         free_idx_s;
  logic                  free_in_range_s;
  logic                  free_legal_s;
  logic                  free_bad_s;
  logic [NUM_CHANS-1:0]  eligible_s;
  logic                  grant_found_s;
  logic [CW-1:0]         grant_idx_s;
  logic [NUM_CHANS-1:0]  grant_vec_s;
  logic                  do_grant_s;
  logic [CW-1:0]         rr_nxt_s;
  logic [CNTW-1:0]       count_nxt_s;
  logic [NUM_TAGS-1:0]   outstanding_nxt_s;

  // Classify the returning tag: only an in-range, currently outstanding tag
  // may re-enter the free list, and only once the pool is running.
  always_comb begin
    head_tag_s      = fifo_mem[rd_ptr_r];
    free_idx_s      = tag_free_tag[TW-1:0];
    free_in_range_s = ({1'b0, tag_free_tag} < TAG_LIMIT);
    free_legal_s    = tag_free_valid && (state_r == ST_RUN) &&
                      free_in_range_s && outstanding_r[free_idx_s];
    free_bad_s      = tag_free_valid && !free_legal_s;
  end

  // Round-robin search from rr; a channel granted last cycle is skipped so
  // it has one cycle to drop its request.
  always_comb begin
    int            cand;
    logic [CW-1:0] cand_idx;
    eligible_s    = alloc_tag_req & ~rdy_r;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand          = 0;
    cand_idx      = '0;
    for (int i = 0; i < NUM_CHANS; i++) begin
      cand     = (int'(rr_r) + i) % NUM_CHANS;
      cand_idx = CW'(cand);
      if (!grant_found_s && eligible_s[cand_idx]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_idx;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    do_grant_s  = (state_r == ST_RUN) && (count_r != '0) && grant_found_s;
    grant_vec_s = '0;
    if (do_grant_s) begin
      grant_vec_s[grant_idx_s] = 1'b1;
    end else begin
      grant_vec_s = '0;
    end
    if (grant_idx_s == LAST_CHAN) begin
      rr_nxt_s = '0;
    end else begin
      rr_nxt_s = grant_idx_s + CHAN_ONE;
    end
  end

  // Next free count and outstanding map; a grant and a legal free in the
  // same cycle cancel in the count.
  always_comb begin
    case ({do_grant_s, free_legal_s})
      2'b10:   count_nxt_s = count_r - CNT_ONE;
      2'b01:   count_nxt_s = count_r + CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    outstanding_nxt_s = outstanding_r;
    if (do_grant_s) begin
      outstanding_nxt_s[head_tag_s[TW-1:0]] = 1'b1;
    end else begin
      outstanding_nxt_s = outstanding_nxt_s;
    end
    if (free_legal_s) begin
      outstanding_nxt_s[free_idx_s] = 1'b0;
    end else begin
      outstanding_nxt_s = outstanding_nxt_s;
    end
  end

  // Free-list storage: seeded with the identity during INIT, then appended
  // at the tail by legal frees. Contents need no reset since INIT rewrites it.
  always_ff @(posedge s_axi_clk) begin
    if (state_r == ST_INIT) begin
      fifo_mem[init_idx_r] <= 8'(init_idx_r);
    end else if (free_legal_s) begin
      fifo_mem[wr_ptr_r] <= tag_free_tag;
    end
  end

  // Pool controller: INIT sequencing, grant registration, pointer and
  // bookkeeping updates, and the sticky free error.
  always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
    if (!s_axi_rstn) begin
      state_r       <= ST_INIT;
      init_idx_r    <= '0;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      count_r       <= '0;
      outstanding_r <= '0;
      rr_r          <= '0;
      rdy_r         <= '0;
      tag_r         <= 8'd0;
      init_done_r   <= 1'b0;
      free_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          rdy_r <= '0;
          if (init_idx_r == LAST_IDX) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
            count_r     <= FULL_COUNT;
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            init_idx_r  <= '0;
          end else begin
            init_idx_r <= init_idx_r + PTR_ONE;
          end
        end
        ST_RUN: begin
          rdy_r         <= grant_vec_s;
          count_r       <= count_nxt_s;
          outstanding_r <= outstanding_nxt_s;
          if (do_grant_s) begin
            tag_r    <= head_tag_s;
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            rr_r     <= rr_nxt_s;
          end
          if (free_legal_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
          end
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
      if (free_bad_s) begin
        free_err_r <= 1'b1;
      end
    end
  end

  assign allocated_tag_rdy = rdy_r;
  assign allocated_tag     = tag_r;
  assign free_count        = count_r;
  assign init_done         = init_done_r;
  assign free_err          = free_err_r;

endmodule

// File: tb/tb_mrd_tag_pool.sv
// Directed bench for mrd_tag_pool (NUM_CHANS=4, NUM_TAGS=32): init timing,
// grant order and latency, round-robin fairness, empty/full behaviour,
// simultaneous grant/free, illegal frees and asynchronous reset.
module tb_mrd_tag_pool;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic [3:0] rdy;
  logic [7:0] tag;
  logic       fv;
  logic [7:0] ft;
  logic [5:0] fcount;
  logic       idone;
  logic       ferr;

  int checks;
  int errors;
  int exp_t;

  mrd_tag_pool #(.NUM_CHANS(4), .NUM_TAGS(32)) dut (
    .s_axi_clk         (clk),
    .s_axi_rstn        (rstn),
    .alloc_tag_req     (req),
    .allocated_tag_rdy (rdy),
    .allocated_tag     (tag),
    .tag_free_valid    (fv),
    .tag_free_tag      (ft),
    .free_count        (fcount),
    .init_done         (idone),
    .free_err          (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic reset_pool();
    rstn = 1'b0;
    req  = 4'b0000;
    fv   = 1'b0;
    ft   = 8'd0;
    tick();
    tick();
    rstn = 1'b1;
    repeat (32) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    req    = 4'b0000;
    fv     = 1'b0;
    ft     = 8'd0;

    // Reset values and INIT duration
    repeat (3) tick();
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_tag", 32'(tag), 32'h0);
    chk("rst_count", 32'(fcount), 32'd0);
    chk("rst_init_done", 32'(idone), 32'd0);
    chk("rst_free_err", 32'(ferr), 32'd0);
    rstn = 1'b1;
    repeat (31) tick();
    chk("init_done_early", 32'(idone), 32'd0);
    chk("init_count_early", 32'(fcount), 32'd0);
    tick();
    chk("init_done_rise", 32'(idone), 32'd1);
    chk("init_count_full", 32'(fcount), 32'd32);
    chk("init_no_grant", 32'(rdy), 32'h0);
    repeat (8) tick();
    chk("idle_count", 32'(fcount), 32'd32);
    chk("idle_free_err", 32'(ferr), 32'd0);

    // Channel 0: three grants, dropping req one cycle after each rdy
    for (int g = 0; g < 3; g++) begin
      req = 4'b0001;
      tick();
      chk("ch0_rdy", 32'(rdy), 32'h1);
      chk("ch0_tag", 32'(tag), 32'(g));
      req = 4'b0000;
      tick();
      chk("ch0_gap", 32'(rdy), 32'h0);
    end
    chk("ch0_count", 32'(fcount), 32'd29);

    // Fresh pool: four channels, two rounds, round-robin from channel 0
    reset_pool();
    chk("rr_count_start", 32'(fcount), 32'd32);
    for (int r = 0; r < 2; r++) begin
      req = 4'b1111;
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("rr_rdy", 32'(rdy), 32'd1 << c);
        chk("rr_tag", 32'(tag), 32'(r * 4 + c));
        req[c] = 1'b0;
      end
    end
    chk("rr_count", 32'(fcount), 32'd24);

    // Single channel holding req: at most every other cycle
    req = 4'b0010;
    tick();
    chk("hold_rdy0", 32'(rdy), 32'h2);
    chk("hold_tag0", 32'(tag), 32'd8);
    tick();
    chk("hold_gap0", 32'(rdy), 32'h0);
    tick();
    chk("hold_rdy1", 32'(rdy), 32'h2);
    chk("hold_tag1", 32'(tag), 32'd9);
    tick();
    chk("hold_gap1", 32'(rdy), 32'h0);
    req = 4'b0000;
    chk("hold_count", 32'(fcount), 32'd22);

    // Grant and legal free of tag 5 in the same cycle
    req = 4'b0001;
    fv  = 1'b1;
    ft  = 8'd5;
    tick();
    chk("gf_rdy", 32'(rdy), 32'h1);
    chk("gf_tag", 32'(tag), 32'd10);
    chk("gf_count", 32'(fcount), 32'd22);
    req = 4'b0000;

    // Free 9 (legal), 9 again (double free), 40 (out of range)
    ft = 8'd9;
    tick();
    chk("free9_count", 32'(fcount), 32'd23);
    chk("free9_err", 32'(ferr), 32'd0);
    tick();
    chk("dbl9_count", 32'(fcount), 32'd23);
    chk("dbl9_err", 32'(ferr), 32'd1);
    ft = 8'd40;
    tick();
    chk("free40_count", 32'(fcount), 32'd23);
    chk("free40_err", 32'(ferr), 32'd1);
    fv = 1'b0;

    // Drain: 11..31 then 5 and 9 from the tail, channels 1 and 0 alternate
    req = 4'b0011;
    for (int i = 0; i < 23; i++) begin
      if (i < 21) exp_t = 11 + i;
      else if (i == 21) exp_t = 5;
      else exp_t = 9;
      tick();
      chk("drain_tag", 32'(tag), 32'(exp_t));
      chk("drain_rdy", 32'(rdy), (i % 2 == 0) ? 32'h2 : 32'h1);
    end
    req = 4'b0010;
    chk("drain_count", 32'(fcount), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("empty_no_grant", 32'(rdy), 32'h0);
    end

    // Free tag 7 into an empty pool; channel 1 gets it two cycles later
    fv = 1'b1;
    ft = 8'd7;
    tick();
    fv = 1'b0;
    chk("refill_rdy_wait", 32'(rdy), 32'h0);
    chk("refill_count", 32'(fcount), 32'd1);
    tick();
    chk("refill_rdy", 32'(rdy), 32'h2);
    chk("refill_tag", 32'(tag), 32'd7);
    chk("refill_count_after", 32'(fcount), 32'd0);
    req = 4'b0000;

    // Asynchronous reset in mid-traffic clears everything immediately
    req = 4'b1111;
    fv  = 1'b1;
    ft  = 8'd3;
    tick();
    chk("pre_rst_err", 32'(ferr), 32'd1);
    chk("pre_rst_count", 32'(fcount), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rdy", 32'(rdy), 32'h0);
    chk("async_count", 32'(fcount), 32'd0);
    chk("async_init_done", 32'(idone), 32'd0);
    chk("async_err", 32'(ferr), 32'd0);
    req  = 4'b0000;
    fv   = 1'b0;
    rstn = 1'b1;
    repeat (31) tick();
    chk("reinit_early", 32'(idone), 32'd0);
    tick();
    chk("reinit_done", 32'(idone), 32'd1);
    chk("reinit_count", 32'(fcount), 32'd32);
    chk("reinit_err", 32'(ferr), 32'd0);

    // Free while full is illegal
    fv = 1'b1;
    ft = 8'd3;
    tick();
    fv = 1'b0;
    chk("full_free_err", 32'(ferr), 32'd1);
    chk("full_free_count", 32'(fcount), 32'd32);

    // Out-of-range free whose low bits alias an outstanding tag
    reset_pool();
    chk("alias_err_clear", 32'(ferr), 32'd0);
    req = 4'b1100;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("alias_tag", 32'(tag), 32'(i));
      chk("alias_rdy", 32'(rdy), (i % 2 == 0) ? 32'h4 : 32'h8);
    end
    req = 4'b0000;
    chk("alias_count", 32'(fcount), 32'd23);
    fv = 1'b1;
    ft = 8'd40;
    tick();
    chk("alias40_err", 32'(ferr), 32'd1);
    chk("alias40_count", 32'(fcount), 32'd23);
    ft = 8'd8;
    tick();
    fv = 1'b0;
    chk("free8_count", 32'(fcount), 32'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
